sfifo_param: RTL
================

// Module: sfifo_param
// PURPOSE
//  Parametrised single-clock synchronous FIFO; successor to the fixed 8x64 sfifo.
//  Adds configurable width/depth, occupancy output, programmable almost-full/empty
//  thresholds, selectable standard or first-word-fall-through (FWFT) read mode,
//  and sticky overflow/underflow with explicit clear. Drop-in buffer between producers/consumers.
// PARAMETERS
//  DATA_W    8          data word width, >=1
//  DEPTH     64         number of entries; power of 2, >=4
//  AF_LEVEL  DEPTH-2    almost_full asserts when level >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2          almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)
//  FWFT      0          0 = standard read (dout registered, 1-cycle latency); 1 = FWFT
//  (AW = log2(DEPTH); LW = AW+1)
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       asynchronous reset, active low
//  w_en          in   1       write request, sampled at posedge clk
//  din           in   DATA_W  write data
//  r_en          in   1       read request (FWFT: pop/acknowledge of head word)
//  err_clr       in   1       synchronous clear of overflow/underflow
//  dout          out  DATA_W  read data
//  full          out  1       level == DEPTH
//  empty         out  1       level == 0
//  almost_full   out  1       level >= AF_LEVEL
//  almost_empty  out  1       level <= AE_LEVEL
//  level         out  LW      current occupancy, 0..DEPTH
//  overflow      out  1       sticky: write rejected
//  underflow     out  1       sticky: read rejected
// BEHAVIOUR
//  - Reset (rst low, async): wr_ptr=rd_ptr=0, level=0, dout=0, overflow=underflow=0,
//    empty=1, almost_empty=1, full=0, almost_full=0. Storage array not reset.
//  - No input flop stage: requests act on the edge where they are sampled.
//  - Flags/level derive from registered level; they reflect state after the last edge, no lag.
//  - Accept rules (evaluated on pre-edge state):
//      rd_ok = r_en & (level != 0)
//      wr_ok = w_en & ((level != DEPTH) | rd_ok)   -- write into full FIFO allowed iff same-cycle read
//  - Empty FIFO + w_en + r_en: write accepted, read rejected (no bypass), underflow set.
//  - level: +1 on wr_ok&!rd_ok, -1 on rd_ok&!wr_ok, unchanged otherwise. Never exceeds DEPTH.
//  - Pointers AW bits, increment on accept, wrap DEPTH-1 -> 0 naturally.
//  - Rejected write: no storage/pointer change, overflow <= 1. Rejected read: underflow <= 1,
//    dout unchanged.
//  - err_clr: clears both sticky flags next edge; a new error in the same cycle wins (flag stays 1).
//  - FWFT=0: on rd_ok, dout <= mem[rd_ptr] at that edge (data valid cycle after r_en);
//    dout holds last read value otherwise.
//  - FWFT=1: dout = mem[rd_ptr] combinationally while !empty, forced 0 when empty;
//    rd_ok advances to next word. Word written to empty FIFO appears on dout the cycle after write.
//  - Reset asserted mid-operation: all state returns to reset values immediately; in-flight
//    requests discarded.
// STRUCTURE
//  - sfifo_pkg: clog2 function, default-parameter constants shared with sfifo testbenches.
//  - Sub-module sfifo_ram: DEPTH x DATA_W, one sync write port, one async read port.
//  - Top holds pointers, level counter, accept logic, flags, dout register/mux.
// TESTING (DEPTH=8, DATA_W=8, AF_LEVEL=6, AE_LEVEL=1 unless stated)
//  1. Reset, write 0x01..0x08 -> level 1..8, almost_full at level 6, full at 8; 9th write -> overflow=1, level=8.
//  2. FWFT=0: read 8 -> dout 0x01..0x08 one cycle after each r_en; extra read -> underflow=1, dout stays 0x08.
//  3. Full + simultaneous w_en/r_en (din=0xAA) -> both accepted, level stays 8, 0xAA read last after wrap.
//  4. Empty + simultaneous w_en/r_en -> level=1, underflow=1; err_clr -> underflow=0 next cycle.
//  5. FWFT=1: write 0x5A to empty -> dout=0x5A next cycle with empty=0; r_en -> empty=1, dout=0.
//  6. Reset asserted at level 5 with w_en high -> level=0, empty=1, flags cleared same cycle.

Source files
------------

// File: rtl/sfifo_pkg.sv
// ============================================================================
// sfifo_pkg : shared constants and helpers for the sfifo family
// Rev 1.0   : initial parametrised release
// ============================================================================
`default_nettype none

package sfifo_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_DEPTH    = 64;
   localparam int DEF_AE_LEVEL = 2;
   localparam int DEF_FWFT     = 0;

   // Ceiling log2, usable in parameter and port-width expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage : sfifo_pkg

`default_nettype wire

// File: rtl/sfifo_ram.sv
// ============================================================================
// sfifo_ram : DEPTH x DATA_W storage, synchronous write, asynchronous read
// Rev 1.0   : initial parametrised release
// ============================================================================
`default_nettype none

module sfifo_ram
   import sfifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AW     = clog2(DEF_DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   // Storage is deliberately not reset; pointers and level define validity.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule : sfifo_ram

`default_nettype wire

// File: rtl/sfifo_param.sv
// ============================================================================
// sfifo_param : parametrised single-clock FIFO, standard or FWFT read mode
// Rev 1.0     : initial parametrised release
// ============================================================================
`default_nettype none

module sfifo_param
   import sfifo_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = DEF_AE_LEVEL,
   parameter int FWFT     = DEF_FWFT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   w_en,
   input  logic [DATA_W-1:0]      din,
   input  logic                   r_en,
   input  logic                   err_clr,
   output logic [DATA_W-1:0]      dout,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [clog2(DEPTH):0]  level,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DATA_W-1:0] rdata;
   logic              rd_ok;
   logic              wr_ok;

   // Acceptance uses pre-edge occupancy; a full FIFO takes a write only
   // when a read frees a slot on the same edge.
   assign rd_ok = r_en & (level != '0);
   assign wr_ok = w_en & ((level != LW'(DEPTH)) | rd_ok);

   assign full         = (level == LW'(DEPTH));
   assign empty        = (level == '0);
   assign almost_full  = (level >= LW'(AF_LEVEL));
   assign almost_empty = (level <= LW'(AE_LEVEL));

   sfifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk    (clk),
      .we     (wr_ok),
      .waddr  (wr_ptr),
      .wdata  (din),
      .raddr  (rd_ptr),
      .rdata  (rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         if (wr_ok && !rd_ok)      level <= level + LW'(1);
         else if (rd_ok && !wr_ok) level <= level - LW'(1);
      end
   end

   // A fresh error in the clearing cycle keeps its flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  & ~err_clr) | (w_en & ~wr_ok);
         underflow <= (underflow & ~err_clr) | (r_en & ~rd_ok);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dout = empty ? '0 : rdata;
      end else begin : g_std
         logic [DATA_W-1:0] dout_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst)       dout_q <= '0;
            else if (rd_ok) dout_q <= rdata;
         end

         assign dout = dout_q;
      end
   endgenerate

endmodule : sfifo_param

`default_nettype wire
